// File: rtl/mem_bist_march_ctrl.sv
// rtl/mem_bist_march_ctrl.sv - March C- BIST sequencer and compare engine for one single-port memory
//
// Ports:
//   bist_clk        clock
//   bist_reset      asynchronous, active-high reset
//   bist_start      start request, honoured only in IDLE or DONE
//   bist_en         memory access enable, high on every op cycle
//   bist_we         1 = write, 0 = read
//   bist_addr       memory address
//   bist_wr_data    write data; holds the expected value during reads
//   bist_rd_data    memory read data, valid RD_LAT cycles after the read op
//   bist_busy       test in progress (RUN or DRAIN)
//   bist_done       test complete, held until restart or reset
//   bist_pass       no miscompare seen; meaningful while bist_done=1
//   bist_fail_addr  address of the first miscompare
//   bist_fail_elem  march element index of the first miscompare
module mem_bist_march_ctrl #(
   parameter int ADDR_W = 2,
   parameter int DATA_W = 64,
   parameter int RD_LAT = 1
) (
   input  logic              bist_clk,
   input  logic              bist_reset,
   input  logic              bist_start,
   output logic              bist_en,
   output logic              bist_we,
   output logic [ADDR_W-1:0] bist_addr,
   output logic [DATA_W-1:0] bist_wr_data,
   input  logic [DATA_W-1:0] bist_rd_data,
   output logic              bist_busy,
   output logic              bist_done,
   output logic              bist_pass,
   output logic [ADDR_W-1:0] bist_fail_addr,
   output logic [2:0]        bist_fail_elem
);

   localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};
   localparam logic [2:0]        LAST_ELEM = 3'd5;
   localparam logic [2:0]        DRAIN_LAST = 3'(RD_LAT - 1);
   localparam int                PL_OUT = RD_LAT - 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t      state;
   logic [2:0]  elem;        // march element of the op currently on the bus
   logic        phase;       // 0 = first op at this address, 1 = second op
   logic [2:0]  drain_cnt;
   logic        fail_flag;

   // Compare pipeline: one stage per cycle of read latency. Since write data
   // is always all-0s or all-1s, one bit is enough to carry the expected value.
   logic [RD_LAT-1:0] pl_valid;
   logic [RD_LAT-1:0] pl_exp;
   logic [ADDR_W-1:0] pl_addr [RD_LAT];
   logic [2:0]        pl_elem [RD_LAT];

   logic              miscompare;
   logic [2:0]        nxt_elem;
   logic              nxt_phase;
   logic [ADDR_W-1:0] nxt_addr;
   logic              run_last;

   // E0 is a single write; E1..E4 are read-then-write; E5 is a single read.
   function automatic logic op_is_write(input logic [2:0] e, input logic ph);
      return (e == 3'd0) || ph;
   endfunction

   // Data bit for an op: reads carry the expected value, writes the new value.
   function automatic logic op_data(input logic [2:0] e, input logic ph);
      if (e == 3'd0)
         return 1'b0;
      else if (!ph)
         return (e == 3'd2) || (e == 3'd4);
      else
         return (e == 3'd1) || (e == 3'd3);
   endfunction

   function automatic logic elem_down(input logic [2:0] e);
      return e >= 3'd3;
   endfunction

   function automatic logic elem_last_phase(input logic [2:0] e, input logic ph);
      return ((e == 3'd0) || (e == LAST_ELEM)) ? 1'b1 : ph;
   endfunction

   assign miscompare = pl_valid[PL_OUT] &&
                       (bist_rd_data != {DATA_W{pl_exp[PL_OUT]}});

   // Next op in the march: step phase, then address, then element.
   always_comb begin
      nxt_elem  = elem;
      nxt_phase = 1'b0;
      nxt_addr  = bist_addr;
      run_last  = 1'b0;
      if (!elem_last_phase(elem, phase)) begin
         nxt_phase = 1'b1;
      end else if (elem_down(elem) ? (bist_addr != '0) : (bist_addr != ADDR_MAX)) begin
         nxt_addr = elem_down(elem) ? (bist_addr - 1'b1) : (bist_addr + 1'b1);
      end else if (elem != LAST_ELEM) begin
         nxt_elem = elem + 3'd1;
         // Explicit reload at each element boundary rather than relying on wrap.
         nxt_addr = elem_down(nxt_elem) ? ADDR_MAX : '0;
      end else begin
         run_last = 1'b1;
      end
   end

   always_ff @(posedge bist_clk or posedge bist_reset) begin
      if (bist_reset) begin
         state          <= S_IDLE;
         elem           <= '0;
         phase          <= 1'b0;
         drain_cnt      <= '0;
         fail_flag      <= 1'b0;
         pl_valid       <= '0;
         pl_exp         <= '0;
         for (int i = 0; i < RD_LAT; i++) begin
            pl_addr[i] <= '0;
            pl_elem[i] <= '0;
         end
         bist_en        <= 1'b0;
         bist_we        <= 1'b0;
         bist_addr      <= '0;
         bist_wr_data   <= '0;
         bist_busy      <= 1'b0;
         bist_done      <= 1'b0;
         bist_pass      <= 1'b0;
         bist_fail_addr <= '0;
         bist_fail_elem <= '0;
      end else begin
         // Track every read issued in RUN through the latency pipeline.
         pl_valid[0] <= (state == S_RUN) && !bist_we;
         pl_exp[0]   <= bist_wr_data[0];
         pl_addr[0]  <= bist_addr;
         pl_elem[0]  <= elem;
         for (int i = 1; i < RD_LAT; i++) begin
            pl_valid[i] <= pl_valid[i-1];
            pl_exp[i]   <= pl_exp[i-1];
            pl_addr[i]  <= pl_addr[i-1];
            pl_elem[i]  <= pl_elem[i-1];
         end

         // First miscompare is sticky; the test keeps running regardless.
         if (miscompare && !fail_flag) begin
            fail_flag      <= 1'b1;
            bist_fail_addr <= pl_addr[PL_OUT];
            bist_fail_elem <= pl_elem[PL_OUT];
         end

         case (state)
            S_IDLE, S_DONE: begin
               if (bist_start) begin
                  state          <= S_RUN;
                  bist_busy      <= 1'b1;
                  bist_done      <= 1'b0;
                  bist_pass      <= 1'b0;
                  fail_flag      <= 1'b0;
                  bist_fail_addr <= '0;
                  bist_fail_elem <= '0;
                  elem           <= '0;
                  phase          <= 1'b0;
                  bist_en        <= 1'b1;
                  bist_we        <= 1'b1;
                  bist_addr      <= '0;
                  bist_wr_data   <= '0;
               end
            end
            S_RUN: begin
               if (run_last) begin
                  state     <= S_DRAIN;
                  bist_en   <= 1'b0;
                  bist_we   <= 1'b0;
                  drain_cnt <= '0;
               end else begin
                  elem         <= nxt_elem;
                  phase        <= nxt_phase;
                  bist_addr    <= nxt_addr;
                  bist_we      <= op_is_write(nxt_elem, nxt_phase);
                  bist_wr_data <= {DATA_W{op_data(nxt_elem, nxt_phase)}};
               end
            end
            S_DRAIN: begin
               // The last read is compared on the same edge that leaves DRAIN,
               // so fold it into the pass result directly.
               if (drain_cnt == DRAIN_LAST) begin
                  state     <= S_DONE;
                  bist_busy <= 1'b0;
                  bist_done <= 1'b1;
                  bist_pass <= !(fail_flag || miscompare);
               end else begin
                  drain_cnt <= drain_cnt + 3'd1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
